// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the RV64 pipeline front end.
package riscv_pkg;

  // FETCH: may issue a request; WAIT: request outstanding, result wanted;
  // DROP: request outstanding, result belongs to a flushed path.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST   = 32'h00000013;
  localparam int          INST_BYTES = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
);

  logic                      imem_req_valid;
  logic                      imem_req_ready;
  logic [XLEN-1:0]           imem_addr;
  logic                      imem_rsp_valid;
  logic                      imem_rsp_ready;
  logic [INST_BYTES*8-1:0]   imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    output imem_rsp_ready,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    input  imem_rsp_ready,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding an instruction and its PC while decode
// is stalled. Clear has priority, then push, then pop.
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [INST_BYTES*8-1:0] in_inst,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    valid,
  output logic [INST_BYTES*8-1:0] out_inst,
  output logic [XLEN-1:0]         out_pc
);

  // Entry register: a flush empties it, a push fills it, a pop empties it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      out_inst <= '0;
      out_pc   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (push) begin
      valid    <= 1'b1;
      out_inst <= in_inst;
      out_pc   <= in_pc;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues one instruction-memory
// request at a time and drives the IF/ID register for decode.
// Optional build macro FETCH_SKID_EN adds a one-entry skid buffer so a
// response can be accepted while decode is stalled.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  fetch_stage_if.master     imem,
  output logic              if_id_valid,
  output logic [31:0]       if_id_inst,
  output logic [XLEN-1:0]   if_id_pc,
  output logic              fetch_misalign
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] issue_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic            blocked;
  logic            req_hs;
  logic            rsp_hs;
  logic            rsp_load;
  logic            can_issue;
  logic            wait_rsp_ready;

  assign blocked          = if_id_valid && id_stall;
  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign req_hs           = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_hs           = imem.imem_rsp_valid && imem.imem_rsp_ready;
  assign rsp_load         = (state == WAIT) && rsp_hs && !redirect_valid;

`ifdef FETCH_SKID_EN
  logic            skid_valid;
  logic [31:0]     skid_inst;
  logic [XLEN-1:0] skid_pc;
  logic            skid_push;
  logic            skid_pop;

  assign skid_push      = rsp_load && blocked;
  assign skid_pop       = skid_valid && !blocked && !redirect_valid;
  assign can_issue      = !blocked || !skid_valid;
  assign wait_rsp_ready = !skid_valid;

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (skid_push),
    .pop      (skid_pop),
    .clear    (redirect_valid),
    .in_inst  (imem.imem_rsp_data),
    .in_pc    (issue_pc),
    .valid    (skid_valid),
    .out_inst (skid_inst),
    .out_pc   (skid_pc)
  );
`else
  assign can_issue      = !blocked;
  assign wait_rsp_ready = !blocked;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // Next state; a response accepted in the same cycle as a redirect has
  // already retired the outstanding request, so there is nothing left to drop.
  always_comb begin
    state_next = state;
    case (state)
      FETCH: if (!redirect_valid && req_hs) state_next = WAIT;
      WAIT: begin
        if (redirect_valid) state_next = rsp_hs ? FETCH : DROP;
        else if (rsp_hs)    state_next = FETCH;
      end
      DROP:    if (rsp_hs) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Memory handshake outputs; responses are refused while in FETCH.
  always_comb begin
    imem.imem_req_valid = 1'b0;
    imem.imem_rsp_ready = 1'b0;
    imem.imem_addr      = pc;
    case (state)
      FETCH:   imem.imem_req_valid = !redirect_valid && can_issue;
      WAIT:    imem.imem_rsp_ready = wait_rsp_ready;
      DROP:    imem.imem_rsp_ready = 1'b1;
      default: imem.imem_req_valid = 1'b0;
    endcase
  end

  // PC update: redirect wins, otherwise advance on an accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      issue_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_aligned;
    end else if (req_hs) begin
      issue_pc <= pc;
      pc       <= pc + XLEN'(INST_BYTES);
    end
  end

  // Misaligned-target pulse, one cycle after the offending redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fetch_misalign <= 1'b0;
    else        fetch_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end

  // IF/ID register: flush, hold while stalled, else load or insert a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
      if_id_pc    <= '0;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end else if (!blocked) begin
`ifdef FETCH_SKID_EN
      if (skid_valid) begin
        if_id_valid <= 1'b1;
        if_id_inst  <= skid_inst;
        if_id_pc    <= skid_pc;
      end else if (rsp_load) begin
        if_id_valid <= 1'b1;
        if_id_inst  <= imem.imem_rsp_data;
        if_id_pc    <= issue_pc;
      end else begin
        if_id_valid <= 1'b0;
        if_id_inst  <= NOP_INST;
      end
`else
      if (rsp_load) begin
        if_id_valid <= 1'b1;
        if_id_inst  <= imem.imem_rsp_data;
        if_id_pc    <= issue_pc;
      end else begin
        if_id_valid <= 1'b0;
        if_id_inst  <= NOP_INST;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural memory plus a
// program-order model of which instruction decode should see next.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_id_valid;
  logic [31:0]     if_id_inst;
  logic [XLEN-1:0] if_id_pc;
  logic            fetch_misalign;

  fetch_stage_if #(.XLEN(XLEN)) bus ();

  fetch_stage #(.XLEN(XLEN), .RESET_PC(64'h0), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .if_id_valid    (if_id_valid),
    .if_id_inst     (if_id_inst),
    .if_id_pc       (if_id_pc),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: memory transaction and the expected program stream.
  logic            mem_pending;
  int              mem_lat;
  logic [XLEN-1:0] mem_addr;
  logic            dropping;
  logic [XLEN-1:0] exp_pc;
  logic [XLEN-1:0] exp_req_addr;
  logic            exp_misalign;
  logic            exp_flush;
  logic            exp_hold;
  int              cyc;
  int              last_consume;
  int              consumed;
  int              blocked_fills;

  // Stimulus knobs and one-shot directed overrides.
  int              stall_pct;
  int              redir_pct;
  int              ready_pct;
  int              min_lat;
  int              max_lat;
  logic            check_rate;
  int              stall_budget;
  logic            force_redir;
  logic [XLEN-1:0] force_pc;
  logic            combo_arm;
  logic [XLEN-1:0] combo_pc;

  function automatic logic [31:0] inst_of(input logic [XLEN-1:0] a);
    return (a[31:0] * 32'd2654435761) ^ a[63:32] ^ 32'h0000_5A03;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic reset_model();
    mem_pending   = 1'b0;
    mem_lat       = 0;
    mem_addr      = '0;
    dropping      = 1'b0;
    exp_pc        = 64'h0;
    exp_req_addr  = 64'h0;
    exp_misalign  = 1'b0;
    exp_flush     = 1'b0;
    exp_hold      = 1'b0;
    last_consume  = -1;
  endtask

  task automatic quiet_inputs();
    id_stall           = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
  endtask

  // One clock: check what the last edge produced, drive this cycle, then
  // predict the effect of the coming edge.
  task automatic applyStimulus();
    logic            blocked;
    logic            rq_hs;
    logic            rs_hs;
    logic [XLEN-1:0] tgt;
    @(negedge clk);
    cyc++;
    checkOutput("fetch_misalign", fetch_misalign, exp_misalign);
    if (exp_flush) checkOutput("flush_valid", if_id_valid, 1'b0);
    if (exp_hold)  checkOutput("stall_hold_valid", if_id_valid, 1'b1);
    if (if_id_valid) begin
      checkOutput("if_id_pc", if_id_pc, exp_pc);
      checkOutput("if_id_inst", if_id_inst, inst_of(exp_pc));
    end else begin
      checkOutput("if_id_nop", if_id_inst, NOP);
    end

    id_stall       = ($urandom_range(99) < stall_pct);
    redirect_valid = ($urandom_range(99) < redir_pct);
    redirect_pc    = ($urandom_range(9) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15)))
                                              : 64'($urandom_range(1023));
    if (stall_budget > 0 && if_id_valid) begin
      id_stall = 1'b1;
      stall_budget--;
    end
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end
    if (combo_arm && if_id_valid) begin
      id_stall       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = combo_pc;
      combo_arm      = 1'b0;
    end
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    bus.imem_rsp_valid = mem_pending && (mem_lat == 0);
    bus.imem_rsp_data  = bus.imem_rsp_valid ? inst_of(mem_addr) : 32'hDEAD_BEEF;
    #1;

    blocked = if_id_valid && id_stall;
    rq_hs   = bus.imem_req_valid && bus.imem_req_ready;
    rs_hs   = bus.imem_rsp_valid && bus.imem_rsp_ready;
    if (redirect_valid) checkOutput("req_quiet_on_redirect", bus.imem_req_valid, 1'b0);
    if (!mem_pending && !redirect_valid && !blocked)
      checkOutput("req_issue", bus.imem_req_valid, 1'b1);
`ifndef FETCH_SKID_EN
    if (!mem_pending && blocked) checkOutput("req_blocked", bus.imem_req_valid, 1'b0);
    if (mem_pending && !dropping) checkOutput("rsp_ready_wait", bus.imem_rsp_ready, !blocked);
`endif
    if (dropping) checkOutput("rsp_ready_drop", bus.imem_rsp_ready, 1'b1);
    if (rq_hs) begin
      checkOutput("single_outstanding", mem_pending, 1'b0);
      checkOutput("imem_addr", bus.imem_addr, exp_req_addr);
    end
    if (rs_hs && blocked && !dropping) blocked_fills++;

    if (if_id_valid && !id_stall && !redirect_valid) begin
      if (check_rate && last_consume >= 0) checkOutput("fetch_rate", cyc - last_consume, 2);
      last_consume = cyc;
      exp_pc       = exp_pc + 64'd4;
      consumed++;
    end

    exp_hold     = blocked && !redirect_valid;
    exp_flush    = redirect_valid;
    exp_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (rs_hs) begin
      mem_pending = 1'b0;
      dropping    = 1'b0;
    end else if (mem_pending && mem_lat > 0) begin
      mem_lat--;
    end
    if (rq_hs) begin
      mem_pending  = 1'b1;
      mem_addr     = bus.imem_addr;
      mem_lat      = int'($urandom_range(max_lat, min_lat)) - 1;
      exp_req_addr = exp_req_addr + 64'd4;
    end
    if (redirect_valid) begin
      tgt          = {redirect_pc[XLEN-1:2], 2'b00};
      exp_pc       = tgt;
      exp_req_addr = tgt;
      if (mem_pending) dropping = 1'b1;
    end
  endtask

  task automatic set_knobs(input int st, input int rd, input int rdy,
                           input int lo, input int hi);
    stall_pct = st;
    redir_pct = rd;
    ready_pct = rdy;
    min_lat   = lo;
    max_lat   = hi;
  endtask

  task automatic wait_pending(input string tag);
    for (int i = 0; i < 40 && !mem_pending; i++) applyStimulus();
    checkOutput(tag, mem_pending, 1'b1);
  endtask

  initial begin
    int start_consumed;
    reset = 1'b0;
    quiet_inputs();
    reset_model();
    cyc = 0; consumed = 0; blocked_fills = 0;
    check_rate = 1'b0; stall_budget = 0;
    force_redir = 1'b0; force_pc = '0; combo_arm = 1'b0; combo_pc = '0;
    set_knobs(0, 0, 100, 1, 1);

    repeat (3) @(negedge clk);
    checkOutput("reset_valid", if_id_valid, 1'b0);
    checkOutput("reset_inst", if_id_inst, NOP);
    checkOutput("reset_pc", if_id_pc, 64'h0);
    checkOutput("reset_misalign", fetch_misalign, 1'b0);
    reset = 1'b1;

    $display("[TB] sequential fetch, 1-cycle memory");
    check_rate = 1'b1;
    repeat (12) applyStimulus();
    check_rate = 1'b0;

    $display("[TB] decode stall for 5 cycles");
    blocked_fills = 0;
    stall_budget  = 5;
    for (int i = 0; i < 30 && stall_budget > 0; i++) applyStimulus();
    checkOutput("stall_window_reached", stall_budget, 0);
`ifdef FETCH_SKID_EN
    checkOutput("blocked_fills", blocked_fills, 1);
`else
    checkOutput("blocked_fills", blocked_fills, 0);
`endif
    repeat (10) applyStimulus();

    $display("[TB] redirect to 0x100 while waiting");
    set_knobs(0, 0, 100, 3, 3);
    wait_pending("wait_before_redirect");
    force_redir = 1'b1;
    force_pc    = 64'h100;
    applyStimulus();
    checkOutput("redirect_in_wait_drops", dropping, 1'b1);
    repeat (12) applyStimulus();

    $display("[TB] redirect and stall together");
    set_knobs(0, 0, 100, 1, 1);
    combo_arm = 1'b1;
    combo_pc  = 64'h200;
    for (int i = 0; i < 30 && combo_arm; i++) applyStimulus();
    checkOutput("combo_reached", combo_arm, 1'b0);
    repeat (10) applyStimulus();

    $display("[TB] misaligned target and PC wrap");
    force_redir = 1'b1;
    force_pc    = 64'h102;
    repeat (8) applyStimulus();
    force_redir = 1'b1;
    force_pc    = 64'hFFFF_FFFF_FFFF_FFFD;
    repeat (10) applyStimulus();

    $display("[TB] asynchronous reset mid-request");
    set_knobs(0, 0, 100, 3, 3);
    wait_pending("wait_before_reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_valid", if_id_valid, 1'b0);
    checkOutput("async_reset_inst", if_id_inst, NOP);
    checkOutput("async_reset_pc", if_id_pc, 64'h0);
    checkOutput("async_reset_rsp_ready", bus.imem_rsp_ready, 1'b0);
    quiet_inputs();
    reset_model();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    set_knobs(0, 0, 100, 1, 1);
    repeat (10) applyStimulus();

    $display("[TB] randomized traffic");
    set_knobs(30, 4, 70, 1, 3);
    start_consumed = consumed;
    repeat (1500) applyStimulus();
    checkOutput("forward_progress", (consumed - start_consumed) >= 50, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
